// File: rtl/lift_pkg.sv
// Shared constants, flag layout and FSM encoding for the 5/3 lifting sequencer.
package lift_pkg;

    localparam int DW = 8;
    localparam int RW = 9;

    localparam int FLAG_EN   = 2;
    localparam int FLAG_FWD  = 1;
    localparam int FLAG_PRED = 0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic logic [2:0] make_flags(input logic pass, input logic fwd);
        logic [2:0] f;
        f            = '0;
        f[FLAG_EN]   = 1'b1;
        f[FLAG_FWD]  = fwd;
        f[FLAG_PRED] = ~pass;
        return f;
    endfunction

endpackage

// File: rtl/lift_row_buf.sv
// One-row sample store with a single write port and a mirrored (i-1, i, i+1) read triple.
module lift_row_buf
    import lift_pkg::*;
#(
    parameter int W  = 16,
    parameter int DW = lift_pkg::DW,
    parameter int AW = $clog2(W)
) (
    input  logic          clk_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic [AW-1:0] idx_i,
    output logic [DW-1:0] left_o,
    output logic [DW-1:0] sam_o,
    output logic [DW-1:0] right_o
);

    logic [DW-1:0] mem_q [W];
    logic [AW-1:0] left_idx;
    logic [AW-1:0] right_idx;

    for (genvar gi = 0; gi < W; gi++) begin : g_mem
        always_ff @(posedge clk_i) begin
            if (wr_en_i && (wr_addr_i == AW'(gi))) begin
                mem_q[gi] <= wr_data_i;
            end
        end
    end

    // Symmetric extension: the edges reflect onto their inner neighbour.
    always_comb begin
        left_idx  = (idx_i == '0) ? AW'(1) : idx_i - AW'(1);
        right_idx = (idx_i == AW'(W - 1)) ? AW'(W - 2) : idx_i + AW'(1);
    end

    assign left_o  = mem_q[left_idx];
    assign sam_o   = mem_q[idx_i];
    assign right_o = mem_q[right_idx];

endmodule

// File: rtl/lift_seq.sv
// Row sequencer for lift_step: loads a row, then issues one mirrored triple per
// predict/update position and forwards each returned result with its index.
module lift_seq
    import lift_pkg::*;
#(
    parameter int W  = 16,
    parameter int DW = lift_pkg::DW,
    parameter int AW = $clog2(W)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 pass_i,
    input  logic                 fwd_i,
    input  logic [DW-1:0]        din_i,
    input  logic                 din_valid_i,
    output logic                 din_ready_o,
    output logic [DW-1:0]        left_o,
    output logic [DW-1:0]        sam_o,
    output logic [DW-1:0]        right_o,
    output logic [2:0]           flags_o,
    output logic                 update_o,
    input  logic signed [RW-1:0] res_i,
    input  logic                 res_valid_i,
    output logic signed [RW-1:0] res_o,
    output logic [AW-1:0]        res_idx_o,
    output logic                 res_valid_o,
    output logic                 busy_o,
    output logic                 done_o
);

    state_t               state_q, state_d;
    logic                 pass_q, pass_d;
    logic                 fwd_q, fwd_d;
    logic [AW-1:0]        cnt_q, cnt_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic                 din_ready_q, din_ready_d;
    logic [DW-1:0]        left_q, left_d;
    logic [DW-1:0]        sam_q, sam_d;
    logic [DW-1:0]        right_q, right_d;
    logic [2:0]           flags_q, flags_d;
    logic                 update_q, update_d;
    logic signed [RW-1:0] res_q, res_d;
    logic [AW-1:0]        res_idx_q, res_idx_d;
    logic                 res_valid_q, res_valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 wr_en;
    logic [AW-1:0]        last_idx;
    logic [DW-1:0]        buf_left, buf_sam, buf_right;

    assign wr_en    = (state_q == LOAD) && din_valid_i && din_ready_q;
    assign last_idx = pass_q ? AW'(W - 2) : AW'(W - 1);

    // Reads use idx_d so the triple lands in the same cycle as update_o. On the
    // final load edge entry W-1 is still being written, but the first position
    // (0 or 1) never reaches it because W >= 4.
    lift_row_buf #(
        .W  (W),
        .DW (DW),
        .AW (AW)
    ) u_row_buf (
        .clk_i     (clk_i),
        .wr_en_i   (wr_en),
        .wr_addr_i (cnt_q),
        .wr_data_i (din_i),
        .idx_i     (idx_d),
        .left_o    (buf_left),
        .sam_o     (buf_sam),
        .right_o   (buf_right)
    );

    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        fwd_d       = fwd_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        left_d      = left_q;
        sam_d       = sam_q;
        right_d     = right_q;
        flags_d     = flags_q;
        update_d    = 1'b0;
        res_d       = res_q;
        res_idx_d   = res_idx_q;
        res_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    pass_d  = pass_i;
                    fwd_d   = fwd_i;
                    cnt_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (wr_en) begin
                    cnt_d = cnt_q + AW'(1);
                    if (cnt_q == AW'(W - 1)) begin
                        idx_d   = pass_q ? AW'(0) : AW'(1);
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (res_valid_i && !update_q) begin
                    res_d       = res_i;
                    res_idx_d   = idx_q;
                    res_valid_d = 1'b1;
                    if (idx_q == last_idx) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + AW'(2);
                        state_d = ISSUE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d == ISSUE) begin
            update_d = 1'b1;
            left_d   = buf_left;
            sam_d    = buf_sam;
            right_d  = buf_right;
            flags_d  = make_flags(pass_q, fwd_q);
        end

        din_ready_d = (state_d == LOAD);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            pass_q      <= 1'b0;
            fwd_q       <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= '0;
            din_ready_q <= 1'b0;
            left_q      <= '0;
            sam_q       <= '0;
            right_q     <= '0;
            flags_q     <= '0;
            update_q    <= 1'b0;
            res_q       <= '0;
            res_idx_q   <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pass_q      <= pass_d;
            fwd_q       <= fwd_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            din_ready_q <= din_ready_d;
            left_q      <= left_d;
            sam_q       <= sam_d;
            right_q     <= right_d;
            flags_q     <= flags_d;
            update_q    <= update_d;
            res_q       <= res_d;
            res_idx_q   <= res_idx_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign din_ready_o = din_ready_q;
    assign left_o      = left_q;
    assign sam_o       = sam_q;
    assign right_o     = right_q;
    assign flags_o     = flags_q;
    assign update_o    = update_q;
    assign res_o       = res_q;
    assign res_idx_o   = res_idx_q;
    assign res_valid_o = res_valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_lift_seq.sv
// Self-checking bench for lift_seq: a W=4 instance driven from a vector table plus
// corner sequences, and a W=16 instance for load backpressure.
module tb_lift_seq;

    typedef struct packed {
        logic [7:0] l;
        logic [7:0] s;
        logic [7:0] r;
        logic [2:0] f;
    } iss_t;

    typedef struct packed {
        logic [3:0] idx;
        logic [8:0] v;
    } res_t;

    typedef struct {
        bit               pass;
        bit               fwd;
        logic [0:3][7:0]  row;
        logic [8:0]       r0;
        logic [8:0]       r1;
        iss_t             e0;
        iss_t             e1;
        logic [3:0]       i0;
        logic [3:0]       i1;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              start4, pass4, fwd4, dv4, rdy4, upd4, rvi4, rvo4, busy4, done4;
    logic [7:0]        din4, l4, s4, r4;
    logic [2:0]        f4;
    logic signed [8:0] resi4, reso4;
    logic [1:0]        idx4;

    logic              start16, pass16, fwd16, dv16, rdy16, upd16, rvi16, rvo16, busy16, done16;
    logic [7:0]        din16, l16, s16, r16;
    logic [2:0]        f16;
    logic signed [8:0] resi16, reso16;
    logic [3:0]        idx16;

    lift_seq #(.W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start4), .pass_i(pass4), .fwd_i(fwd4),
        .din_i(din4), .din_valid_i(dv4), .din_ready_o(rdy4),
        .left_o(l4), .sam_o(s4), .right_o(r4), .flags_o(f4), .update_o(upd4),
        .res_i(resi4), .res_valid_i(rvi4), .res_o(reso4), .res_idx_o(idx4),
        .res_valid_o(rvo4), .busy_o(busy4), .done_o(done4)
    );

    lift_seq #(.W(16)) dut16 (
        .clk_i(clk), .rst_i(rst), .start_i(start16), .pass_i(pass16), .fwd_i(fwd16),
        .din_i(din16), .din_valid_i(dv16), .din_ready_o(rdy16),
        .left_o(l16), .sam_o(s16), .right_o(r16), .flags_o(f16), .update_o(upd16),
        .res_i(resi16), .res_valid_i(rvi16), .res_o(reso16), .res_idx_o(idx16),
        .res_valid_o(rvo16), .busy_o(busy16), .done_o(done16)
    );

    int   checks   = 0;
    int   failures = 0;
    int   iss_cnt4 = 0;
    int   iss_cnt16 = 0;
    int   upd_load16 = 0;
    bit   loading16 = 1'b0;
    iss_t q_iss4[$];
    iss_t q_iss16[$];
    res_t q_res4[$];
    res_t q_res16[$];
    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Scoreboard monitors: every strobe pops the next expected record.
    always @(negedge clk) begin
        if (upd4) begin
            iss_cnt4++;
            if (q_iss4.size() == 0) check("iss4_unexpected", 1, 0);
            else check("iss4_triple", {l4, s4, r4, f4}, q_iss4.pop_front());
        end
        if (rvo4) begin
            if (q_res4.size() == 0) check("res4_unexpected", 1, 0);
            else check("res4_value", {2'b00, idx4, reso4}, q_res4.pop_front());
        end
        if (upd16) begin
            iss_cnt16++;
            if (loading16) upd_load16++;
            if (q_iss16.size() == 0) check("iss16_unexpected", 1, 0);
            else check("iss16_triple", {l16, s16, r16, f16}, q_iss16.pop_front());
        end
        if (rvo16) begin
            if (q_res16.size() == 0) check("res16_unexpected", 1, 0);
            else check("res16_value", {idx16, reso16}, q_res16.pop_front());
        end
    end

    task automatic load4(input logic [0:3][7:0] row);
        int k = 0;
        int g = 0;
        dv4  = 1'b1;
        din4 = row[0];
        while (k < 4 && g < 50) begin
            @(negedge clk);
            g++;
            if (rdy4) k++;
            @(posedge clk);
            #1;
            if (k < 4) din4 = row[k];
        end
        dv4 = 1'b0;
        if (k != 4) check("load4_timeout", k, 4);
    endtask

    task automatic respond4(input logic [8:0] resp, input int hold);
        int   g = 0;
        iss_t held;
        do begin
            @(negedge clk);
            g++;
        end while (!upd4 && g < 100);
        if (!upd4) check("issue4_timeout", 0, 1);
        held = {l4, s4, r4, f4};
        if (hold > 0) begin
            int bad_upd = 0;
            int bad_tri = 0;
            repeat (hold) begin
                @(negedge clk);
                if (upd4) bad_upd++;
                if ({l4, s4, r4, f4} !== held) bad_tri++;
            end
            check("hold_no_reissue", bad_upd, 0);
            check("hold_triple_stable", bad_tri, 0);
        end
        @(posedge clk);
        #1;
        resi4 = resp;
        rvi4  = 1'b1;
        @(posedge clk);
        #1;
        rvi4  = 1'b0;
    endtask

    task automatic wait_done4();
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!done4 && g < 50);
        check("done4_pulse", done4, 1);
        @(negedge clk);
        check("done4_one_cycle", {done4, busy4}, 2'b00);
    endtask

    task automatic run4(input vec_t v, input int hold);
        q_iss4.push_back(v.e0);
        q_iss4.push_back(v.e1);
        q_res4.push_back({v.i0, v.r0});
        q_res4.push_back({v.i1, v.r1});
        iss_cnt4 = 0;
        @(posedge clk);
        #1;
        start4 = 1'b1;
        pass4  = v.pass;
        fwd4   = v.fwd;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        load4(v.row);
        respond4(v.r0, hold);
        respond4(v.r1, 0);
        wait_done4();
        check("iss4_count", iss_cnt4, 2);
    endtask

    logic [7:0] row16 [16];
    logic [8:0] resp16 [8];

    initial begin
        rst = 1'b1;
        {start4, pass4, fwd4, dv4, rvi4, start16, pass16, fwd16, dv16, rvi16} = '0;
        din4 = '0; resi4 = '0; din16 = '0; resi16 = '0;

        vecs[0] = '{1'b0, 1'b1, {8'd68, 8'd218, 8'd163, 8'd231}, 9'h1FB, 9'd255,
                    {8'd68, 8'd218, 8'd163, 3'd7}, {8'd163, 8'd231, 8'd163, 3'd7}, 4'd1, 4'd3};
        vecs[1] = '{1'b1, 1'b0, {8'd68, 8'd218, 8'd163, 8'd231}, 9'd12, 9'd34,
                    {8'd218, 8'd68, 8'd218, 3'd4}, {8'd218, 8'd163, 8'd231, 3'd4}, 4'd0, 4'd2};
        vecs[2] = '{1'b0, 1'b0, {8'd10, 8'd20, 8'd30, 8'd40}, 9'd0, 9'h100,
                    {8'd10, 8'd20, 8'd30, 3'd5}, {8'd30, 8'd40, 8'd30, 3'd5}, 4'd1, 4'd3};
        vecs[3] = '{1'b1, 1'b1, {8'd1, 8'd2, 8'd3, 8'd4}, 9'd100, 9'h1FF,
                    {8'd2, 8'd1, 8'd2, 3'd6}, {8'd2, 8'd3, 8'd4, 3'd6}, 4'd0, 4'd2};

        repeat (3) @(posedge clk);
        #1;
        check("reset4_outputs", {rdy4, l4, s4, r4, f4, upd4, reso4, idx4, rvo4, busy4, done4}, 0);
        check("reset16_outputs", {rdy16, l16, s16, r16, f16, upd16, reso16, idx16, rvo16, busy16, done16}, 0);
        rst = 1'b0;

        for (int v = 0; v < 4; v++) run4(vecs[v], 0);

        // Slow lift_step: first result withheld for 50 cycles.
        run4(vecs[0], 50);

        // Stray result strobe while idle.
        @(posedge clk);
        #1;
        resi4 = 9'sd77;
        rvi4  = 1'b1;
        @(posedge clk);
        #1;
        rvi4 = 1'b0;
        begin
            int seen = 0;
            repeat (3) begin
                @(negedge clk);
                if (rvo4) seen++;
            end
            check("spurious_res_ignored", seen, 0);
        end

        // Reset while waiting on the first result.
        q_iss4.push_back(vecs[0].e0);
        @(posedge clk);
        #1;
        start4 = 1'b1;
        pass4  = vecs[0].pass;
        fwd4   = vecs[0].fwd;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        load4(vecs[0].row);
        begin
            int g = 0;
            do begin
                @(negedge clk);
                g++;
            end while (!upd4 && g < 100);
            check("rst_pre_issue", upd4, 1);
        end
        @(posedge clk);
        #2;
        check("rst_pre_busy", busy4, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", {rdy4, l4, s4, r4, f4, upd4, reso4, idx4, rvo4, busy4, done4}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run4(vecs[0], 0);

        // W=16 predict forward with random load backpressure.
        for (int i = 0; i < 16; i++) row16[i] = 8'($urandom_range(0, 255));
        for (int k = 0; k < 8; k++) begin
            int ix;
            ix = 2 * k + 1;
            resp16[k] = 9'($urandom_range(0, 511));
            q_iss16.push_back({row16[ix - 1], row16[ix], (ix == 15) ? row16[14] : row16[ix + 1], 3'd7});
            q_res16.push_back({4'(ix), resp16[k]});
        end
        @(posedge clk);
        #1;
        start16 = 1'b1;
        pass16  = 1'b0;
        fwd16   = 1'b1;
        @(posedge clk);
        #1;
        start16   = 1'b0;
        loading16 = 1'b1;
        begin
            int k = 0;
            int g = 0;
            while (k < 16 && g < 500) begin
                dv16  = 1'($urandom_range(0, 1));
                din16 = row16[k];
                @(negedge clk);
                g++;
                if (dv16 && rdy16) k++;
                @(posedge clk);
                #1;
            end
            dv16      = 1'b0;
            loading16 = 1'b0;
            check("load16_accepted", k, 16);
        end
        @(negedge clk);
        check("ready16_low_after_load", rdy16, 0);
        check("no_update_during_load16", upd_load16, 0);
        for (int k = 0; k < 8; k++) begin
            int g = 0;
            if (k > 0) begin
                do begin
                    @(negedge clk);
                    g++;
                end while (!upd16 && g < 100);
            end
            if (!upd16) check("issue16_timeout", 0, 1);
            @(posedge clk);
            #1;
            resi16 = resp16[k];
            rvi16  = 1'b1;
            @(posedge clk);
            #1;
            rvi16 = 1'b0;
        end
        begin
            int g = 0;
            do begin
                @(negedge clk);
                g++;
            end while (!done16 && g < 50);
            check("done16_pulse", done16, 1);
        end
        check("iss16_count", iss_cnt16, 8);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", q_iss4.size() + q_res4.size() + q_iss16.size() + q_res16.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
